mixer_gain_ramper: RTL and testbench
====================================

Name: mixer_gain_ramper

Overview:
Controller for the 4-input mixer gain inputs (n1..n4). Host logic writes per-channel target gains. Once per audio frame (DACLRC rising edge), the block moves each channel's live gain toward its target by a fixed step, which removes the zipper noise that abrupt gain changes cause. It sits between control logic (button/UART/sequencer) and the mixer, and runs in the system clock domain with a synchronised lrclk.

Parameters:
BITSIZE, 24, width of gain words (unsigned; 24'h100000 = 2^20 scale as used by mixer)
STEP, 24'h010000, per-frame gain increment/decrement magnitude
INIT_GAIN, 24'h000000, reset value of every target and live gain

Ports:
clk  in  1  system clock (>= 64x lrclk rate)
rst_n  in  1  asynchronous active-low reset
lrclk  in  1  codec DACLRC, asynchronous to clk
wr_en  in  1  target write strobe, accepted only when wr_ready=1
wr_ch  in  2  target channel index 0..3
wr_gain  in  BITSIZE  new target gain
wr_ready  out  1  high when writes are accepted (state IDLE)
mute  in  1  level; forces the effective target to 0 on all channels
n1,n2,n3,n4  out  BITSIZE  live gains to mixer, registered
ramping  out  1  registered; high if any live gain != its effective target
frame_done  out  1  one-clk pulse after channel 3 is updated

Behaviour:
- Reset (async, rst_n=0): n1..n4 = INIT_GAIN; targets = INIT_GAIN; state IDLE; sync flops and pending = 0; ramping = 0; frame_done = 0; wr_ready = 1 from first clk after release.
- lrclk sync: 2-FF synchroniser plus a delay flop. A frame edge is detected in cycle t when sync=1 and delayed=0.
- FSM states: IDLE, UPD0, UPD1, UPD2, UPD3.
  - IDLE -> UPD0 on edge or pending.
  - UPDk -> UPDk+1 unconditionally.
  - UPD3 -> IDLE.
- Update timing: in UPDk, channel k live gain is updated (channel 0 drives n1). With an edge at t, n1 changes at t+2, n4 at t+5, frame_done pulses at t+5, and ramping is refreshed at t+5.
- Effective target: tgt_k = mute ? 0 : target_k. Mute is sampled in each UPDk state.
- Step rule (computed in BITSIZE+1 bits, no wrap):
  - cur < tgt: cur = min(cur+STEP, tgt).
  - cur > tgt: cur = max(cur-STEP, tgt).
  - equal: hold.
  - Landing exactly on target (clamp) is mandatory. Never overshoot; never wrap past 0 or 2^BITSIZE-1.
- Writes: wr_ready = (state==IDLE). When wr_en && wr_ready, target[wr_ch] <= wr_gain next clk. Writes with wr_ready=0 are dropped (no queue). A write in the same cycle as an edge detect is accepted; the frame that follows uses the new target.
- Edge during UPD0..UPD3: set pending. After UPD3, go to IDLE for exactly one cycle (one write slot), then run the frame. Only one pending edge is kept.
- Mute toggling mid-frame: channels already updated keep their step; the remaining channels use the new mute value.
- Reset mid-frame: immediate async clear to reset values; any partial frame is discarded.
- lrclk static: outputs hold indefinitely; writes remain accepted.

Decomposition:
- Shared package (mixer_pkg): BITSIZE default, channel count NCH=4, FSM state encoding, ramp step helper function (clamped add/sub).
- Sub-module: lrclk_edge_sync (2-FF sync + rising-edge pulse). It is reusable by the i2s and sequencer blocks.

Test Plan:
- Reset with INIT_GAIN=0, toggle lrclk -> n1..n4 = 0, ramping=0, wr_ready=1, frame_done pulses once per lrclk rise.
- Write ch0 = 24'h030000, run 4 frames -> n1 = 010000, 020000, 030000, 030000. ramping is 1 after frames 1-2 and 0 after frame 3. n2..n4 stay 0.
- Ch1 at 030000, write target 008000 -> n2 = 020000, 010000, 008000 (clamp), then held.
- Targets ch0..3 = 020000, assert mute -> all step to 010000 then 000000. Release mute -> back to 020000 in 2 frames; targets unchanged.
- Hold wr_en during UPD1 -> wr_ready=0, target unchanged. Inject a second lrclk edge during UPD2 -> one extra frame runs after a one-cycle IDLE; no edge is lost.
- Saturation, with ch3 at FF8000 and target FFFFFF -> n4 = FFFFFF next frame, no wrap. Then pulse rst_n low mid-UPD2 -> all n = INIT_GAIN immediately, FSM IDLE.

Source files
------------

// File: rtl/mixer_gain_ramper_pkg.sv
// Shared types, sizes and the clamped ramp-step helper for the mixer gain ramper.
package mixer_gain_ramper_pkg;

  localparam int unsigned BITSIZE = 24;
  localparam int unsigned NCH     = 4;
  localparam int unsigned CH_W    = 2;

  typedef logic [BITSIZE-1:0] gain_t;
  typedef logic [CH_W-1:0]    ch_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UPD0,
    ST_UPD1,
    ST_UPD2,
    ST_UPD3
  } state_t;

  // Move cur one step toward tgt, landing exactly on tgt and never wrapping.
  function automatic gain_t ramp_step(input gain_t cur, input gain_t tgt, input gain_t step);
    logic [BITSIZE:0] sum;
    logic [BITSIZE:0] dif;
    gain_t            res;
    sum = {1'b0, cur} + {1'b0, step};
    dif = {1'b0, cur} - {1'b0, step};
    res = cur;
    if (cur < tgt) begin
      res = (sum > {1'b0, tgt}) ? tgt : sum[BITSIZE-1:0];
    end else if (cur > tgt) begin
      res = (dif[BITSIZE] || (dif[BITSIZE-1:0] < tgt)) ? tgt : dif[BITSIZE-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mixer_gain_ramper_if.sv
// Target-write handshake between host control logic and the gain ramper.
interface mixer_gain_ramper_if;
  import mixer_gain_ramper_pkg::*;

  logic  wr_en;
  ch_t   wr_ch;
  gain_t wr_gain;
  logic  wr_ready;

  modport master (output wr_en, output wr_ch, output wr_gain, input wr_ready);
  modport slave  (input wr_en, input wr_ch, input wr_gain, output wr_ready);
endinterface

// File: rtl/mixer_gain_ramper_edge_sync.sv
// Two-flop synchroniser for lrclk plus a delay flop giving a rising-edge pulse.
module lrclk_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic lrclk,
  output logic rise_c
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  // Shift the async level through the synchroniser and delay stage.
  always_comb begin
    sync1_d = lrclk;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  // Synchroniser and delay registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign rise_c = sync2_q & ~dly_q;

endmodule

// File: rtl/mixer_gain_ramper.sv
// Per-frame gain ramper: steps each live mixer gain toward its target once per lrclk rise.
module mixer_gain_ramper
  import mixer_gain_ramper_pkg::*;
#(
  parameter gain_t STEP      = 24'h010000,
  parameter gain_t INIT_GAIN = 24'h000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lrclk,
  input  logic                 mute,
  mixer_gain_ramper_if.slave   wr,
  output gain_t                n1,
  output gain_t                n2,
  output gain_t                n3,
  output gain_t                n4,
  output logic                 ramping,
  output logic                 frame_done
);

  logic   edge_c;
  state_t state_q, state_d;
  logic   pending_q, pending_d;
  gain_t  target_q [NCH];
  gain_t  target_d [NCH];
  gain_t  gain_q   [NCH];
  gain_t  gain_d   [NCH];
  gain_t  tgt_c    [NCH];
  logic   ramping_q, ramping_d;
  logic   frame_done_q, frame_done_d;
  logic   wr_ready_q, wr_ready_d;

  lrclk_edge_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .lrclk  (lrclk),
    .rise_c (edge_c)
  );

  // Effective target: mute pulls every channel toward zero without touching stored targets.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      tgt_c[CH_W'(i)] = mute ? '0 : target_q[CH_W'(i)];
    end
  end

  // Next-state, target writes, per-channel update and frame status.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    target_d     = target_q;
    gain_d       = gain_q;
    ramping_d    = ramping_q;
    frame_done_d = 1'b0;

    if (wr.wr_en && (state_q == ST_IDLE)) begin
      target_d[wr.wr_ch] = wr.wr_gain;
    end

    if ((state_q != ST_IDLE) && edge_c) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (edge_c || pending_q) begin
          state_d   = ST_UPD0;
          pending_d = 1'b0;
        end
      end
      ST_UPD0: begin
        gain_d[0] = ramp_step(gain_q[0], tgt_c[0], STEP);
        state_d   = ST_UPD1;
      end
      ST_UPD1: begin
        gain_d[1] = ramp_step(gain_q[1], tgt_c[1], STEP);
        state_d   = ST_UPD2;
      end
      ST_UPD2: begin
        gain_d[2] = ramp_step(gain_q[2], tgt_c[2], STEP);
        state_d   = ST_UPD3;
      end
      ST_UPD3: begin
        gain_d[3]    = ramp_step(gain_q[3], tgt_c[3], STEP);
        state_d      = ST_IDLE;
        frame_done_d = 1'b1;
        ramping_d    = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
          if (gain_d[CH_W'(i)] != tgt_c[CH_W'(i)]) ramping_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wr_ready_d = (state_d == ST_IDLE);
  end

  // State, targets, live gains and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      ramping_q    <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ready_q   <= 1'b1;
      for (int unsigned i = 0; i < NCH; i++) begin
        target_q[CH_W'(i)] <= INIT_GAIN;
        gain_q[CH_W'(i)]   <= INIT_GAIN;
      end
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      ramping_q    <= ramping_d;
      frame_done_q <= frame_done_d;
      wr_ready_q   <= wr_ready_d;
      target_q     <= target_d;
      gain_q       <= gain_d;
    end
  end

  assign n1          = gain_q[0];
  assign n2          = gain_q[1];
  assign n3          = gain_q[2];
  assign n4          = gain_q[3];
  assign ramping     = ramping_q;
  assign frame_done  = frame_done_q;
  assign wr.wr_ready = wr_ready_q;

endmodule

// File: tb/tb_mixer_gain_ramper.sv
// Directed bench for mixer_gain_ramper with hand-computed gain trajectories.
module tb_mixer_gain_ramper;
  import mixer_gain_ramper_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  lrclk;
  logic  mute;
  gain_t n1, n2, n3, n4;
  logic  ramping;
  logic  frame_done;
  gain_t gn [4];

  int n_cmp = 0;
  int n_bad = 0;

  mixer_gain_ramper_if wr_if ();

  mixer_gain_ramper dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lrclk      (lrclk),
    .mute       (mute),
    .wr         (wr_if.slave),
    .n1         (n1),
    .n2         (n2),
    .n3         (n3),
    .n4         (n4),
    .ramping    (ramping),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  assign gn[0] = n1;
  assign gn[1] = n2;
  assign gn[2] = n3;
  assign gn[3] = n4;

  // One lrclk rise in a fixed 16-cycle window; returns the frame_done pulse count.
  task automatic run_frame(output int pulses);
    pulses = 0;
    @(negedge clk);
    lrclk = 1'b1;
    repeat (12) begin
      @(negedge clk);
      pulses += int'(frame_done);
    end
    lrclk = 1'b0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(frame_done);
    end
  endtask

  task automatic do_write(input ch_t ch, input gain_t g);
    @(negedge clk);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_ch   = ch;
    wr_if.wr_gain = g;
    @(negedge clk);
    wr_if.wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    int p;
    rst_n = 1'b0; lrclk = 1'b0; mute = 1'b0;
    wr_if.wr_en = 1'b0; wr_if.wr_ch = '0; wr_if.wr_gain = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (gn[i] !== 24'h0) begin n_bad++; $display("FAIL reset_n%0d got %h want 000000", i + 1, gn[i]); end
    end
    n_cmp++;
    if (ramping !== 1'b0) begin n_bad++; $display("FAIL reset_ramping got %b want 0", ramping); end
    n_cmp++;
    if (wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got %b want 1", wr_if.wr_ready); end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    for (int f = 0; f < 2; f++) begin
      run_frame(p);
      n_cmp++;
      if (p !== 1) begin n_bad++; $display("FAIL reset_pulses frame %0d got %0d want 1", f, p); end
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (gn[i] !== 24'h0) begin n_bad++; $display("FAIL idle_frame_n%0d got %h want 000000", i + 1, gn[i]); end
      end
      n_cmp++;
      if (ramping !== 1'b0) begin n_bad++; $display("FAIL idle_frame_ramping got %b want 0", ramping); end
    end
  endtask

  task automatic test_ramp_up();
    int    p;
    gain_t exp_n1 [4];
    logic  exp_rp [4];
    exp_n1 = '{24'h010000, 24'h020000, 24'h030000, 24'h030000};
    exp_rp = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_write(2'd0, 24'h030000);
    for (int f = 0; f < 4; f++) begin
      run_frame(p);
      n_cmp++;
      if (p !== 1) begin n_bad++; $display("FAIL up_pulses frame %0d got %0d want 1", f, p); end
      n_cmp++;
      if (n1 !== exp_n1[f]) begin n_bad++; $display("FAIL up_n1 frame %0d got %h want %h", f, n1, exp_n1[f]); end
      n_cmp++;
      if ({n2, n3, n4} !== 72'h0) begin n_bad++; $display("FAIL up_others frame %0d got %h %h %h want 0", f, n2, n3, n4); end
      n_cmp++;
      if (ramping !== exp_rp[f]) begin n_bad++; $display("FAIL up_ramping frame %0d got %b want %b", f, ramping, exp_rp[f]); end
    end
  endtask

  task automatic test_ramp_down();
    int    p;
    gain_t exp_n2 [4];
    logic  exp_rp [4];
    exp_n2 = '{24'h020000, 24'h010000, 24'h008000, 24'h008000};
    exp_rp = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_write(2'd1, 24'h030000);
    repeat (3) run_frame(p);
    n_cmp++;
    if (n2 !== 24'h030000) begin n_bad++; $display("FAIL down_setup_n2 got %h want 030000", n2); end
    do_write(2'd1, 24'h008000);
    for (int f = 0; f < 4; f++) begin
      run_frame(p);
      n_cmp++;
      if (n2 !== exp_n2[f]) begin n_bad++; $display("FAIL down_n2 frame %0d got %h want %h", f, n2, exp_n2[f]); end
      n_cmp++;
      if (ramping !== exp_rp[f]) begin n_bad++; $display("FAIL down_ramping frame %0d got %b want %b", f, ramping, exp_rp[f]); end
    end
  endtask

  task automatic test_mute();
    int    p;
    gain_t exp [4];
    for (int c = 0; c < 4; c++) do_write(ch_t'(c), 24'h020000);
    run_frame(p);
    exp = '{24'h020000, 24'h018000, 24'h010000, 24'h010000};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (gn[i] !== exp[i]) begin n_bad++; $display("FAIL settle1_n%0d got %h want %h", i + 1, gn[i], exp[i]); end
    end
    run_frame(p);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (gn[i] !== 24'h020000) begin n_bad++; $display("FAIL settle2_n%0d got %h want 020000", i + 1, gn[i]); end
    end
    mute = 1'b1;
    for (int f = 0; f < 2; f++) begin
      run_frame(p);
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (gn[i] !== ((f == 0) ? 24'h010000 : 24'h000000)) begin
          n_bad++; $display("FAIL mute_n%0d frame %0d got %h", i + 1, f, gn[i]);
        end
      end
      n_cmp++;
      if (ramping !== (f == 0)) begin n_bad++; $display("FAIL mute_ramping frame %0d got %b want %b", f, ramping, f == 0); end
    end
    mute = 1'b0;
    for (int f = 0; f < 2; f++) begin
      run_frame(p);
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (gn[i] !== ((f == 0) ? 24'h010000 : 24'h020000)) begin
          n_bad++; $display("FAIL unmute_n%0d frame %0d got %h", i + 1, f, gn[i]);
        end
      end
    end
    n_cmp++;
    if (ramping !== 1'b0) begin n_bad++; $display("FAIL unmute_ramping got %b want 0", ramping); end
  endtask

  task automatic test_back_to_back();
    int p;
    int pulses = 0;
    do_write(2'd2, 24'h040000);
    @(negedge clk);
    lrclk = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      pulses += int'(frame_done);
      case (k)
        0: lrclk = 1'b0;
        2: lrclk = 1'b1;
        3: begin
          n_cmp++;
          if (wr_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL busy_wr_ready got %b want 0", wr_if.wr_ready); end
          wr_if.wr_en = 1'b1; wr_if.wr_ch = 2'd0; wr_if.wr_gain = 24'hFFFFFF;
        end
        4: wr_if.wr_en = 1'b0;
        6: begin
          n_cmp++;
          if (wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL gap_wr_ready got %b want 1", wr_if.wr_ready); end
          n_cmp++;
          if (frame_done !== 1'b1) begin n_bad++; $display("FAIL first_done got %b want 1", frame_done); end
          n_cmp++;
          if (n3 !== 24'h030000) begin n_bad++; $display("FAIL first_n3 got %h want 030000", n3); end
        end
        7: begin
          n_cmp++;
          if (wr_if.wr_ready !== 1'b0) begin n_bad++; $display("FAIL pending_start got %b want 0", wr_if.wr_ready); end
        end
        11: begin
          n_cmp++;
          if (frame_done !== 1'b1) begin n_bad++; $display("FAIL second_done got %b want 1", frame_done); end
          n_cmp++;
          if (n3 !== 24'h040000) begin n_bad++; $display("FAIL second_n3 got %h want 040000", n3); end
        end
        default: ;
      endcase
    end
    n_cmp++;
    if (pulses !== 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    lrclk = 1'b0;
    repeat (4) @(negedge clk);
    run_frame(p);
    n_cmp++;
    if (n1 !== 24'h020000) begin n_bad++; $display("FAIL dropped_write_n1 got %h want 020000", n1); end
    n_cmp++;
    if (ramping !== 1'b0) begin n_bad++; $display("FAIL b2b_ramping got %b want 0", ramping); end
  endtask

  task automatic test_saturation();
    int p;
    do_write(2'd3, 24'hFF8000);
    for (int f = 0; f < 300; f++) begin
      run_frame(p);
      if (n4 === 24'hFF8000) break;
    end
    n_cmp++;
    if (n4 !== 24'hFF8000) begin n_bad++; $display("FAIL sat_reach_n4 got %h want FF8000", n4); end
    do_write(2'd3, 24'hFFFFFF);
    for (int f = 0; f < 2; f++) begin
      run_frame(p);
      n_cmp++;
      if (n4 !== 24'hFFFFFF) begin n_bad++; $display("FAIL sat_n4 frame %0d got %h want FFFFFF", f, n4); end
      n_cmp++;
      if (ramping !== 1'b0) begin n_bad++; $display("FAIL sat_ramping frame %0d got %b want 0", f, ramping); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int p;
    int pulses = 0;
    do_write(2'd0, 24'h040000);
    @(negedge clk);
    lrclk = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (n1 !== 24'h030000) begin n_bad++; $display("FAIL mid_frame_n1 got %h want 030000", n1); end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (gn[i] !== 24'h0) begin n_bad++; $display("FAIL async_rst_n%0d got %h want 000000", i + 1, gn[i]); end
    end
    n_cmp++;
    if (wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_wr_ready got %b want 1", wr_if.wr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    lrclk = 1'b0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(frame_done);
    end
    n_cmp++;
    if (pulses !== 0) begin n_bad++; $display("FAIL discarded_frame pulses got %0d want 0", pulses); end
    n_cmp++;
    if (wr_if.wr_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_wr_ready got %b want 1", wr_if.wr_ready); end
    run_frame(p);
    n_cmp++;
    if (p !== 1) begin n_bad++; $display("FAIL post_rst_pulses got %0d want 1", p); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (gn[i] !== 24'h0) begin n_bad++; $display("FAIL post_rst_n%0d got %h want 000000", i + 1, gn[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_mute();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
